// File: rtl/codbebida_enc.sv
// ---------------------------------------------------------------------------
// codbebida_enc -- drink-selection encoder (transmit side of the drink-code
// decoder).
//
// Turns the one-hot drink buttons into the 5-bit drink code {X,Y,Z,A,B}.
// Button index i maps to code i+1; code 0 means "nothing selected".
// A press must be stable for DEB_CYCLES consecutive samples before it is
// accepted. The accepted selection is held until the user confirms, cancels
// or the selection times out. A confirmed code is then handed to the
// dispenser.
//
// Optional build macro:
//   CODBEB_SYNC_EN  btn, confirm and cancel pass through 2-flop synchronizers
//                   (reset to 0) before any logic; every input-to-response
//                   latency grows by 2 cycles. busy/done are not synchronized.
//                   Leave it undefined when the inputs are already synchronous
//                   to clk.
//
// Parameters:
//   N_BTN       number of drink buttons (1..31)
//   DEB_CYCLES  consecutive identical samples needed to accept a press (>=1)
//   TIMEOUT     idle cycles in the held-selection state before auto-cancel (>=1)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   btn          drink buttons, level, one-hot when valid
//   confirm      user confirm, level
//   cancel       user cancel, level
//   busy         dispenser busy; confirm is ignored while high
//   done         dispenser finished, 1-cycle pulse
//   X,Y,Z,A,B    drink code, X is bit 4 (MSB), B is bit 0 (LSB)
//   code_valid   1-cycle pulse: the code on X..B is handed to the dispenser
//   sel_pending  a selection is held and waiting for confirm
//   multi        two or more buttons were high in the last sample
//
// Dispenser handshake: a confirm with busy low produces exactly one
// code_valid pulse; the code then stays on X..B and every user input is
// ignored until the dispenser returns a one-cycle done pulse, which blanks
// the code. busy acts as "not ready": confirm never produces code_valid while
// busy is high, and the request is simply re-evaluated on each later cycle.
//
// All outputs are registered. The FSM state is held in `state`
// (IDLE, DEBOUNCE, SELECTED, DISPATCH, WAIT_DONE).
// ---------------------------------------------------------------------------
module codbebida_enc #(
    parameter int N_BTN      = 8,
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    input  logic             confirm,
    input  logic             cancel,
    input  logic             busy,
    input  logic             done,
    output logic             X,
    output logic             Y,
    output logic             Z,
    output logic             A,
    output logic             B,
    output logic             code_valid,
    output logic             sel_pending,
    output logic             multi
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DEBOUNCE  = 3'd1,
        S_SELECTED  = 3'd2,
        S_DISPATCH  = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] s_btn;
    logic             s_confirm;
    logic             s_cancel;

`ifdef CODBEB_SYNC_EN
    logic [N_BTN-1:0] btn_meta;
    logic             confirm_meta;
    logic             cancel_meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta     <= '0;
            confirm_meta <= 1'b0;
            cancel_meta  <= 1'b0;
            s_btn        <= '0;
            s_confirm    <= 1'b0;
            s_cancel     <= 1'b0;
        end else begin
            btn_meta     <= btn;
            confirm_meta <= confirm;
            cancel_meta  <= cancel;
            s_btn        <= btn_meta;
            s_confirm    <= confirm_meta;
            s_cancel     <= cancel_meta;
        end
    end
`else
    assign s_btn     = btn;
    assign s_confirm = confirm;
    assign s_cancel  = cancel;
`endif

    // ------------------------------------------------------------------
    // Sample classification: how many buttons are high, and the code of
    // the (only) high button when exactly one is high. hot_code is only
    // meaningful when one_hot is set.
    // ------------------------------------------------------------------
    logic [5:0] pop;
    logic [4:0] hot_code;
    logic       one_hot;
    logic       many;

    always_comb begin
        pop      = '0;
        hot_code = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (s_btn[i]) begin
                pop      = pop + 6'd1;
                hot_code = 5'(i + 1);
            end
        end
    end

    assign one_hot = (pop == 6'd1);
    assign many    = (pop >= 6'd2);

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    state_t           state;
    logic [4:0]       code_q;      // code shown on X..B
    logic [N_BTN-1:0] cand_vec;    // button pattern being debounced
    logic [4:0]       cand_code;   // code it would produce
    logic [N_BTN-1:0] sel_vec;     // button pattern of the held selection
    logic             from_sel;    // debounce started from SELECTED (fall back there)
    logic             armed;       // buttons seen all-zero since the last selection ended
    logic [DW-1:0]    deb_cnt;
    logic [TW-1:0]    tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            code_q      <= '0;
            cand_vec    <= '0;
            cand_code   <= '0;
            sel_vec     <= '0;
            from_sel    <= 1'b0;
            armed       <= 1'b1;
            deb_cnt     <= '0;
            tmo_cnt     <= '0;
            code_valid  <= 1'b0;
            sel_pending <= 1'b0;
            multi       <= 1'b0;
        end else begin
            multi      <= many;
            code_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    code_q      <= '0;
                    sel_pending <= 1'b0;
                    if (s_btn == '0) begin
                        armed <= 1'b1;
                    end else if (armed && one_hot) begin
                        cand_vec  <= s_btn;
                        cand_code <= hot_code;
                        from_sel  <= 1'b0;
                        if (DEB_CYCLES <= 1) begin
                            // A single sample is already enough.
                            state       <= S_SELECTED;
                            code_q      <= hot_code;
                            sel_vec     <= s_btn;
                            sel_pending <= 1'b1;
                            tmo_cnt     <= '0;
                        end else begin
                            state   <= S_DEBOUNCE;
                            deb_cnt <= DW'(1);
                        end
                    end
                end

                S_DEBOUNCE: begin
                    // cand_vec is one-hot, so equality also rules out multi.
                    if (s_btn == cand_vec) begin
                        if (deb_cnt >= DW'(DEB_CYCLES - 1)) begin
                            state       <= S_SELECTED;
                            code_q      <= cand_code;
                            sel_vec     <= cand_vec;
                            sel_pending <= 1'b1;
                            tmo_cnt     <= '0;
                            deb_cnt     <= DW'(DEB_CYCLES);
                        end else begin
                            deb_cnt <= deb_cnt + DW'(1);
                        end
                    end else begin
                        // Candidate dropped: return to where we came from.
                        // code_q is untouched, so a held selection stays shown.
                        deb_cnt <= '0;
                        if (from_sel) begin
                            state       <= S_SELECTED;
                            sel_pending <= 1'b1;
                            tmo_cnt     <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_SELECTED: begin
                    if (s_cancel) begin
                        state       <= S_IDLE;
                        code_q      <= '0;
                        sel_pending <= 1'b0;
                        armed       <= 1'b0;
                        tmo_cnt     <= '0;
                    end else if (s_confirm && !busy) begin
                        state       <= S_DISPATCH;
                        code_valid  <= 1'b1;
                        sel_pending <= 1'b0;
                        tmo_cnt     <= '0;
                    end else if (one_hot && (s_btn != sel_vec)) begin
                        cand_vec  <= s_btn;
                        cand_code <= hot_code;
                        from_sel  <= 1'b1;
                        tmo_cnt   <= '0;
                        if (DEB_CYCLES <= 1) begin
                            code_q  <= hot_code;
                            sel_vec <= s_btn;
                        end else begin
                            state       <= S_DEBOUNCE;
                            sel_pending <= 1'b0;
                            deb_cnt     <= DW'(1);
                        end
                    end else if (tmo_cnt >= TW'(TIMEOUT - 1)) begin
                        state       <= S_IDLE;
                        code_q      <= '0;
                        sel_pending <= 1'b0;
                        armed       <= 1'b0;
                        tmo_cnt     <= '0;
                    end else begin
                        // Busy-blocked confirm and re-press of the held
                        // button both count as inactivity.
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                S_DISPATCH: begin
                    state <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    if (done) begin
                        state  <= S_IDLE;
                        code_q <= '0;
                        armed  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign {X, Y, Z, A, B} = code_q;

endmodule
